// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default width/counter sizing.
package serial_subtractor_pkg;

    localparam int SUB_WIDTH = 4;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
// Purely combinational; reused once per clock by the serial loop.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // difference and borrow from the full-subtractor truth table
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: B = Sum - A mod 2^WIDTH, one bit per clock, LSB first.
// Optional macro BORROW_OUT_EN exposes the registered final borrow as a port.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Sum,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B
`ifdef BORROW_OUT_EN
    ,
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH);

    sub_state_e state_q, state_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
`ifdef BORROW_OUT_EN
    logic             bo_q, bo_d;
`endif

    logic d_w;
    logic bout_w;
    logic last_w;

    full_subtractor_bit u_fsb (
        .a    (sum_q[0]),
        .b    (a_q[0]),
        .bin  (bin_q),
        .d    (d_w),
        .bout (bout_w)
    );

    assign last_w = (cnt_q == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: accept in IDLE, count bits in SHIFT, wait for drain in DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_w)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs decoded straight from the state flops
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // datapath next-state: capture, shift one bit per cycle, publish on last bit
    always_comb begin
        sum_d = sum_q;
        a_d   = a_q;
        res_d = res_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        bin_d = bin_q;
`ifdef BORROW_OUT_EN
        bo_d  = bo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d = Sum;
                    a_d   = A;
                    cnt_d = '0;
                    bin_d = 1'b0;
                end
            end
            SHIFT: begin
                sum_d = sum_q >> 1;
                a_d   = a_q >> 1;
                res_d = {d_w, res_q[WIDTH-1:1]};
                bin_d = bout_w;
                cnt_d = cnt_q + 1'b1;
                if (last_w) begin
                    b_d = {d_w, res_q[WIDTH-1:1]};
`ifdef BORROW_OUT_EN
                    bo_d = bout_w;
`endif
                end
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            a_q   <= '0;
            res_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            bin_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            a_q   <= a_d;
            res_q <= res_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            bin_q <= bin_d;
        end
    end

`ifdef BORROW_OUT_EN
    // published final borrow, held alongside B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo_q <= 1'b0;
        end else begin
            bo_q <= bo_d;
        end
    end

    assign borrow = bo_q;
`endif

    assign B = b_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Reference model is plain modular arithmetic on the operand pair.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Sum;
    logic [3:0] A;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] B;
`ifdef BORROW_OUT_EN
    logic       borrow;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .B         (B)
`ifdef BORROW_OUT_EN
        ,
        .borrow    (borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_diff(input logic [3:0] s,
                                            input logic [3:0] a);
        int d;
        d = int'(s) - int'(a);
        return 4'(d & 15);
    endfunction

    function automatic logic ref_borrow(input logic [3:0] s,
                                        input logic [3:0] a);
        return int'(s) < int'(a);
    endfunction

    task automatic txn(input logic [3:0] s, input logic [3:0] a,
                       input int hold, input bit chk_lat,
                       input bit chk_add);
        int         w;
        int         lat;
        logic [3:0] eb;
        logic       ebo;
        eb  = ref_diff(s, a);
        ebo = ref_borrow(s, a);
        @(negedge clk);
        Sum       = s;
        A         = a;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Sum      = 4'($urandom);
        A        = 4'($urandom);
        chk("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", out_valid, 1);
        if (chk_lat) chk("latency", lat, 4);
        chk("B", B, eb);
`ifdef BORROW_OUT_EN
        chk("borrow", borrow, ebo);
`endif
        if (chk_add) chk("adder_inverse", 4'(B + a), s);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_B", B, eb);
`ifdef BORROW_OUT_EN
            chk("hold_borrow", borrow, ebo);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 0);
        chk("drain_in_ready", in_ready, 1);
        chk("B_held", B, eb);
        if (ebo !== 1'bx) ;
    endtask

    logic [3:0] qs[3];
    logic [3:0] qa[3];
    logic [3:0] qb[3];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Sum       = '0;
        A         = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_B", B, 0);
`ifdef BORROW_OUT_EN
        chk("rst_borrow", borrow, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        txn(4'd9, 4'd3, 0, 1, 1);
        txn(4'd3, 4'd9, 0, 1, 1);
        txn(4'd0, 4'd1, 0, 1, 1);

        // abort two cycles into SHIFT
        @(negedge clk);
        Sum      = 4'd5;
        A        = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_B", B, 0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(4'd15, 4'd15, 0, 1, 1);

        txn(4'd12, 4'd7, 7, 1, 1);

        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 16; a++)
                txn(4'(s), 4'(a), 0, 0, 1);

        for (int r = 0; r < 30; r++)
            txn(4'($urandom), 4'($urandom), $urandom_range(0, 3), 1, 1);

        for (int k = 0; k < 3; k++) begin
            qs[k] = 4'($urandom);
            qa[k] = 4'($urandom);
            qb[k] = ref_diff(qs[k], qa[k]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int w;
                    @(negedge clk);
                    Sum      = qs[k];
                    A        = qa[k];
                    in_valid = 1'b1;
                    w = 0;
                    while (!in_ready && w < 40) begin
                        @(negedge clk);
                        w++;
                    end
                    @(posedge clk);
                end
                #1;
                in_valid = 1'b0;
            end
            begin
                int last;
                last = 0;
                for (int k = 0; k < 3; k++) begin
                    int w;
                    w = 0;
                    do begin
                        @(posedge clk);
                        #1;
                        w++;
                    end while (!out_valid && w < 40);
                    chk("b2b_out_valid", out_valid, 1);
                    chk("b2b_B", B, qb[k]);
                    if (k > 0) chk("b2b_period", cyc - last, 6);
                    last = cyc;
                end
            end
        join
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor that recovers operand B from a sum and operand A (B = Sum − A mod 2^WIDTH), the inverse of the combinational WIDTH-bit adder. It sits behind the adder datapath and takes one operand pair per transaction over a valid/ready handshake. It processes one bit per clock, LSB first, and presents the result on a second valid/ready handshake.

## Interface
- WIDTH, 4, operand and result width in bits; must be ≥ 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  Sum and A are valid.
- in_ready  output  1  block can accept an operand pair.
- Sum  input  WIDTH  minuend.
- A  input  WIDTH  subtrahend.
- out_valid  output  1  B is valid.
- out_ready  input  1  downstream accepts B.
- B  output  WIDTH  result, Sum − A mod 2^WIDTH.
- borrow  output  1  final borrow, Sum < A unsigned. Present only with BORROW_OUT_EN.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, Sum and A are captured into shift registers.
  - The bit counter and the borrow flop are cleared.
  - The state moves to SHIFT.
- SHIFT:
  - Each cycle, d = Sum[0] ^ A[0] ^ bin.
  - bout = (~Sum[0] & A[0]) | (~(Sum[0] ^ A[0]) & bin).
  - d shifts into the MSB of the result register, which shifts right.
  - Both operand registers shift right, bin takes bout, and the counter increments.
  - After the bit where count == WIDTH−1, the state moves to DONE.
- DONE:
  - out_valid=1; B and borrow are held stable.
  - On out_valid&&out_ready, the state moves to IDLE.
  - out_valid stays high until the handshake completes; there is no timeout.
- Arithmetic: the result is modulo 2^WIDTH, and wrap-around is normal operation. borrow equals the final bout.
- in_valid is ignored outside IDLE. Sum and A may change freely after capture.
- Reset asserted mid-transaction aborts immediately. The captured data is discarded and the state returns to IDLE.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, B=0, borrow=0.
  - Internal counter, borrow flop and shift registers are all 0.
- Accept handshake at edge t:
  - in_ready is low from t.
  - Bit i of the result is computed at edge t+1+i.
  - out_valid rises at edge t+WIDTH. Latency is WIDTH cycles.
- Output handshake at edge u:
  - out_valid falls and in_ready rises at u.
  - The earliest next accept is edge u+1.
  - Sustained throughput is one result per WIDTH+2 cycles when out_ready is held high.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is not accepted that cycle.
- B holds its last value after the output handshake until the next result is complete.
- B changes only at the SHIFT-to-DONE transition edge.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- BORROW_OUT_EN:
  - Defined: the borrow port exists, is registered, and is valid whenever out_valid=1.
  - Undefined: the port is absent and the internal borrow is used only for chaining within the serial loop.
  - B, timing and handshake are identical in both builds.

## Structure
- The shared package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the counter width constant, clog2(WIDTH);
  - the full-subtractor truth-table function, if preferred over a sub-module.
- Sub-module full_subtractor_bit: inputs a, b, bin; outputs d, bout. It is purely combinational and instantiated once in the serial loop.
- The FSM, counter and shift registers live in serial_subtractor itself.

## Test plan
All scenarios use WIDTH=4.

- Basic: Sum=9, A=3, out_ready=1 → B=6, borrow=0; out_valid rises exactly 4 cycles after the accept edge.
- Wrap: Sum=3, A=9 → B=0xA, borrow=1. Also Sum=0, A=1 → B=0xF, borrow=1.
- Exhaustive: every Sum/A pair 0..15 → B == (Sum−A)&0xF and borrow == (Sum<A); B+A mod 16 matches the adder output for the same pair.
- Backpressure: out_ready held 0 for 7 cycles after out_valid rises → B, borrow and out_valid are stable and in_ready=0; in_valid pulses are ignored; after out_ready=1, in_ready rises at the next edge.
- Reset mid-operation: assert rst_n=0 two cycles into SHIFT → out_valid=0, in_ready=1, B=0 immediately; a fresh transaction Sum=15, A=15 → B=0, borrow=0.
- Back-to-back: in_valid held high with out_ready=1 and 3 queued pairs → results arrive in order, with one pair per 6 cycles.
